// File: rtl/fproc_arbiter.sv
// ============================================================================
// Module   : fproc_arbiter
// Purpose  : Round-robin sharing of one fproc resource among N_CORES cores.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fproc_arbiter #(
  parameter int N_CORES        = 4,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_CORES-1:0]                core_fproc_en,
  input  logic [N_CORES*FPROC_ID_WIDTH-1:0] core_fproc_id,
  output logic [N_CORES-1:0]                core_fproc_ready,
  output logic [DATA_WIDTH-1:0]             core_fproc_data,
  output logic                              fproc_en_out,
  output logic [FPROC_ID_WIDTH-1:0]         fproc_id_out,
  input  logic                              fproc_ready,
  input  logic [DATA_WIDTH-1:0]             fproc_data,
  output logic                              dup_req_err,
  output logic                              timeout_err
);

  localparam int C_GW = $clog2(N_CORES);
  localparam int C_CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [N_CORES-1:0]        pending_q, pending_d;
  logic [FPROC_ID_WIDTH-1:0] id_q [N_CORES];
  logic [FPROC_ID_WIDTH-1:0] id_d [N_CORES];
  logic [C_GW-1:0]           grant_q, grant_d;
  logic [C_GW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [C_CW-1:0]           cnt_q, cnt_d;
  logic                      en_out_q, en_out_d;
  logic [FPROC_ID_WIDTH-1:0] id_out_q, id_out_d;
  logic [N_CORES-1:0]        core_ready_q, core_ready_d;
  logic [DATA_WIDTH-1:0]     core_data_q, core_data_d;
  logic                      dup_err_q, dup_err_d;
  logic                      to_err_q, to_err_d;

  logic                      sel_valid;
  logic [C_GW-1:0]           sel_idx;
  logic                      timed_out;

  // First pending core at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    sel_valid = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!sel_valid && pending_q[idx]) begin
        sel_valid = 1'b1;
        sel_idx   = C_GW'(idx);
      end
    end
  end

  assign timed_out = (TIMEOUT_CYCLES > 0) && (cnt_q == C_CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    id_d         = id_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    en_out_d     = en_out_q;
    id_out_d     = id_out_q;
    core_ready_d = '0;
    core_data_d  = core_data_q;
    dup_err_d    = dup_err_q;
    to_err_d     = to_err_q;

    for (int i = 0; i < N_CORES; i++) begin
      if (core_fproc_en[i]) begin
        if (pending_q[i]) begin
          dup_err_d = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          id_d[i]      = core_fproc_id[i*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          grant_d  = sel_idx;
          id_out_d = id_q[sel_idx];
          en_out_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        en_out_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A real result takes priority over a timeout landing in the same cycle.
        if (fproc_ready || timed_out) begin
          core_data_d           = fproc_ready ? fproc_data : '0;
          to_err_d              = to_err_q | ~fproc_ready;
          core_ready_d[grant_q] = 1'b1;
          pending_d[grant_q]    = 1'b0;
          rr_ptr_d = (grant_q == C_GW'(N_CORES - 1)) ? '0 : grant_q + 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      en_out_q     <= 1'b0;
      id_out_q     <= '0;
      core_ready_q <= '0;
      core_data_q  <= '0;
      dup_err_q    <= 1'b0;
      to_err_q     <= 1'b0;
      for (int i = 0; i < N_CORES; i++) id_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      en_out_q     <= en_out_d;
      id_out_q     <= id_out_d;
      core_ready_q <= core_ready_d;
      core_data_q  <= core_data_d;
      dup_err_q    <= dup_err_d;
      to_err_q     <= to_err_d;
      for (int i = 0; i < N_CORES; i++) id_q[i] <= id_d[i];
    end
  end

  assign core_fproc_ready = core_ready_q;
  assign core_fproc_data  = core_data_q;
  assign fproc_en_out     = en_out_q;
  assign fproc_id_out     = id_out_q;
  assign dup_req_err      = dup_err_q;
  assign timeout_err      = to_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fproc_arbiter.sv
// ============================================================================
// Module   : tb_fproc_arbiter
// Purpose  : Directed scoreboard bench for fproc_arbiter (4 cores, timeout 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fproc_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  core_fproc_en = '0;
  logic [31:0] core_fproc_id = '0;
  logic [3:0]  core_fproc_ready;
  logic [31:0] core_fproc_data;
  logic        fproc_en_out;
  logic [7:0]  fproc_id_out;
  logic        fproc_ready = 1'b0;
  logic [31:0] fproc_data = '0;
  logic        dup_req_err;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_id[$];
  logic [35:0] exp_res[$];

  fproc_arbiter #(
    .N_CORES(4), .FPROC_ID_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .core_fproc_en(core_fproc_en), .core_fproc_id(core_fproc_id),
    .core_fproc_ready(core_fproc_ready), .core_fproc_data(core_fproc_data),
    .fproc_en_out(fproc_en_out), .fproc_id_out(fproc_id_out),
    .fproc_ready(fproc_ready), .fproc_data(fproc_data),
    .dup_req_err(dup_req_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every issue and every core result must match the next queued expectation.
  always @(negedge clk) begin
    if (fproc_en_out === 1'b1) begin
      chk("issue_expected", 64'(exp_id.size() != 0), 64'd1);
      if (exp_id.size() != 0) chk("issue_id", 64'(fproc_id_out), 64'(exp_id.pop_front()));
    end
    if (core_fproc_ready !== 4'b0000) begin
      chk("ready_onehot", 64'($countones(core_fproc_ready)), 64'd1);
      chk("result_expected", 64'(exp_res.size() != 0), 64'd1);
      if (exp_res.size() != 0) chk("result", 64'({core_fproc_ready, core_fproc_data}), 64'(exp_res.pop_front()));
    end
  end

  task automatic wait_issue();
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (fproc_en_out === 1'b1) found = 1'b1;
      else tick();
    end
    chk("issue_seen", 64'(found), 64'd1);
  endtask

  // Answer the current grant after lat cycles; returns in the cycle the result is visible.
  task automatic serve(input int lat, input logic [3:0] onehot, input logic [31:0] data);
    wait_issue();
    repeat (lat) tick();
    fproc_ready = 1'b1;
    fproc_data  = data;
    exp_res.push_back({onehot, data});
    tick();
    fproc_ready = 1'b0;
    chk("serve_ready", 64'(core_fproc_ready), 64'(onehot));
    chk("serve_data", 64'(core_fproc_data), 64'(data));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_outputs", 64'({core_fproc_ready, core_fproc_data, fproc_en_out, fproc_id_out, dup_req_err, timeout_err}), 64'd0);
    chk("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    reset = 1'b0;
    tick();

    // Single request: core 2, ID 0x15
    core_fproc_en = 4'b0100;
    core_fproc_id = 32'h0015_0000;
    exp_id.push_back(8'h15);
    tick();
    core_fproc_en = '0;
    chk("single_t1_no_issue", 64'(fproc_en_out), 64'd0);
    tick();
    chk("single_t2_issue", 64'({fproc_en_out, fproc_id_out}), 64'h115);
    serve(3, 4'b0100, 32'hDEAD_BEEF);
    tick();
    chk("single_pulse_once", 64'(core_fproc_ready), 64'd0);
    chk("single_data_hold", 64'({core_fproc_data, fproc_id_out}), 64'hDEAD_BEEF_15);

    // Reset mid-WAIT with cores 0 and 2 pending (rr_ptr=3, so core 0 is granted)
    core_fproc_en = 4'b0101;
    core_fproc_id = 32'h00B2_00B0;
    exp_id.push_back(8'hB0);
    tick();
    core_fproc_en = '0;
    wait_issue();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_outputs", 64'({core_fproc_ready, core_fproc_data, fproc_en_out, fproc_id_out, dup_req_err, timeout_err}), 64'd0);
    chk("midrst_pending", 64'(dut.pending_q), 64'd0);
    tick();
    tick();
    fproc_ready = 1'b1;
    fproc_data  = 32'h1234_5678;
    tick();
    fproc_ready = 1'b0;
    repeat (4) tick();
    chk("midrst_no_ready", 64'({core_fproc_ready, core_fproc_data}), 64'd0);

    // Contention: cores 0, 1, 3 together
    core_fproc_en = 4'b1011;
    core_fproc_id = 32'hA300_A1A0;
    exp_id.push_back(8'hA0);
    exp_id.push_back(8'hA1);
    exp_id.push_back(8'hA3);
    tick();
    core_fproc_en = '0;
    serve(3, 4'b0001, 32'h0000_00D0);
    tick();
    chk("next_issue_r2", 64'({fproc_en_out, fproc_id_out}), 64'h1A1);
    serve(3, 4'b0010, 32'h0000_00D1);
    serve(3, 4'b1000, 32'h0000_00D3);
    chk("rr_wrap", 64'(dut.rr_ptr_q), 64'd0);
    tick();
    core_fproc_en = 4'b1001;
    core_fproc_id = 32'hC300_00C0;
    exp_id.push_back(8'hC0);
    exp_id.push_back(8'hC3);
    tick();
    core_fproc_en = '0;
    serve(2, 4'b0001, 32'h0000_C0C0);
    serve(2, 4'b1000, 32'h0000_C3C3);

    // Duplicate request from core 1
    tick();
    core_fproc_en = 4'b0010;
    core_fproc_id = 32'h0000_0100;
    exp_id.push_back(8'h01);
    tick();
    core_fproc_id = 32'h0000_0200;
    tick();
    core_fproc_en = '0;
    chk("dup_err_set", 64'(dup_req_err), 64'd1);
    serve(2, 4'b0010, 32'h0000_1111);
    repeat (4) tick();
    chk("dup_single_pulse", 64'({core_fproc_ready, fproc_en_out}), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("dup_err_cleared", 64'(dup_req_err), 64'd0);
    tick();

    // Back-to-back: core 3 re-requests in the cycle its result is visible
    core_fproc_en = 4'b1000;
    core_fproc_id = 32'h3300_0000;
    exp_id.push_back(8'h33);
    tick();
    core_fproc_en = '0;
    wait_issue();
    repeat (2) tick();
    fproc_ready = 1'b1;
    fproc_data  = 32'hAAAA_0003;
    exp_res.push_back({4'b1000, 32'hAAAA_0003});
    tick();
    fproc_ready = 1'b0;
    chk("b2b_ready", 64'(core_fproc_ready), 64'h8);
    core_fproc_en = 4'b1000;
    core_fproc_id = 32'h3400_0000;
    exp_id.push_back(8'h34);
    tick();
    core_fproc_en = '0;
    chk("b2b_r2_idle", 64'(fproc_en_out), 64'd0);
    tick();
    chk("b2b_r3_issue", 64'({fproc_en_out, fproc_id_out}), 64'h134);
    chk("b2b_no_dup", 64'(dup_req_err), 64'd0);
    serve(1, 4'b1000, 32'hAAAA_0004);

    // Timeout: resource never answers core 1
    tick();
    core_fproc_en = 4'b0010;
    core_fproc_id = 32'h0000_7700;
    exp_id.push_back(8'h77);
    tick();
    core_fproc_en = '0;
    wait_issue();
    exp_res.push_back({4'b0010, 32'h0});
    repeat (9) tick();
    chk("to_not_early", 64'({core_fproc_ready, timeout_err}), 64'd0);
    tick();
    chk("to_ready", 64'({core_fproc_ready, core_fproc_data, timeout_err}), {27'd0, 4'b0010, 32'h0, 1'b1});
    tick();
    fproc_ready = 1'b1;
    fproc_data  = 32'hFFFF_FFFF;
    tick();
    fproc_ready = 1'b0;
    repeat (3) tick();
    chk("to_late_ignored", 64'({core_fproc_ready, core_fproc_data}), 64'd0);
    chk("to_err_sticky", 64'(timeout_err), 64'd1);

    tick();
    chk("sb_ids_drained", 64'(exp_id.size()), 64'd0);
    chk("sb_results_drained", 64'(exp_res.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
